conv_viterbi_codec: RTL and testbench
=====================================

Name: conv_viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision 4-state Viterbi decoder, in one block.
- Sits in the tx/rx link. Encoder output is registered externally, may have bit errors injected, and is then fed back into the decoder input.
- Encoder and decoder paths share clk/rst only; they are otherwise independent.

Parameters:
- TB_DEPTH, 16: survivor (register-exchange) length in symbols; fixed decoder latency.
- PM_W, 8: path-metric width in bits.
- PM_INIT, 32: reset metric for states 1..3 (state 0 resets to 0).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enc_enable_i  in  1  encoder input bit is valid this cycle.
- enc_d_in  in  1  encoder data bit.
- enc_valid_o  out  1  enc_d_out is valid.
- enc_d_out  out  2  coded symbol {g1,g0}.
- dec_enable  in  1  dec_d_in symbol is valid this cycle.
- dec_d_in  in  2  received symbol {r1,r0}, possibly corrupted.
- dec_d_out  out  1  decoded bit.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst). All flops clear on rst low, regardless of clock.

Encoder:
- Shift register s[1:0]; s[1] holds the most recent bit. Reset: s=0, enc_d_out=0, enc_valid_o=0.
- enc_valid_o is registered enc_enable_i (1-cycle latency), updated every cycle.
- On a cycle with enc_enable_i=1:
  - enc_d_out <= {d^s[1]^s[0], d^s[0]}, with d=enc_d_in (generators 7,5 octal).
  - s <= {d, s[1]}.
- With enc_enable_i=0: s and enc_d_out hold.

Decoder trellis:
- State = encoder s[1:0].
- Next state ns = {b, s[1]} for input bit b.
- The two predecessors of ns are {ns[0],0} and {ns[0],1}.
- Expected symbol for edge s->ns is {b^s[1]^s[0], b^s[0]}, with b=ns[1].

Decoder, per cycle with dec_enable=1:
- Branch metric = Hamming distance between dec_d_in and the expected symbol (0..2).
- ACS: cand = pm[pred] + bm. Pick the smaller candidate; on a tie pick the predecessor with s[0]=0.
- Normalize: new pm[ns] = cand_min[ns] − min over all four cand_min.
  - Arithmetic is unsigned PM_W bits; additions saturate at 2^PM_W−1.
- Survivor (register exchange): surv[ns] <= {surv[winner][TB_DEPTH-2:0], ns[1]}.
- Output: dec_d_out <= surv[best][TB_DEPTH-1], using pre-update registers.
  - best = state with minimum pre-update pm; ties go to the lowest index.
- Latency: the decoded bit for the j-th enabled symbol appears on dec_d_out after enabled update j+TB_DEPTH.
- With dec_enable=0: pm, surv and dec_d_out hold.

Decoder reset:
- pm[0]=0, pm[1..3]=PM_INIT.
- surv all 0, dec_d_out=0.

End-to-end:
- Error-free input bit k reappears TB_DEPTH decoder updates later, plus the pipeline delays of the encoder and any external register.
- Leading outputs during warm-up are 0.

Boundary conditions:
- Reset mid-stream restarts both trellises from state 0.
- Gaps in dec_enable stretch latency in clocks but never alter the decoded bits.
- Any single symbol error separated from the next error by at least TB_DEPTH/2 symbols is corrected.

Decomposition:
- Package conv_codec_pkg:
  - NUM_STATES=4.
  - Typedef state_t (2 bits).
  - Function exp_sym(state_t s, logic b) returning 2 bits.
  - Function hamming2.
- Sub-module conv_encoder: the encoder path, also reusable standalone.
- Decoder ACS, survivor and output logic stay in the top block as generate loops over the states.

Test Plan:
- Reset check: hold rst=0 mid-operation -> all outputs 0 immediately; pm={0,32,32,32} after release.
- Encoder impulse: enc_d_in=1 once then 0s, enable every cycle -> enc_d_out sequence 11,10,11,00,00; enc_valid_o lags enable by 1 cycle.
- Clean loopback: 256 random bits, enable always on -> dec_d_out equals input delayed by TB_DEPTH updates plus pipeline; 0 mismatches.
- Single-bit errors: flip dec_d_in[0] once every 32 symbols -> 0 decoded-bit errors.
- Double-symbol burst: invert both bits for 2 consecutive symbols every 32 symbols -> decoder resynchronizes; errors confined to a window of at most TB_DEPTH bits per burst; count reported.
- Enable gaps: dec_enable toggled 1/0 randomly with clean input -> decoded stream identical to the continuous-enable run.

Source files
------------

// File: rtl/conv_codec_pkg.sv
// rtl/conv_codec_pkg.sv - shared trellis types and helpers for the (7,5) K=3 codec
package conv_codec_pkg;

  localparam int NUM_STATES = 4;

  typedef logic [1:0] state_t;

  // Coded symbol {g1,g0} emitted when bit b is shifted into encoder state s.
  function automatic logic [1:0] exp_sym(state_t s, logic b);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 K=3 convolutional encoder, generators 7,5 octal
module conv_encoder
  import conv_codec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       d_i,
  output logic       valid_o,
  output logic [1:0] d_o
);

  state_t     s_q, s_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q;

  always_comb begin
    s_d   = s_q;
    sym_d = sym_q;
    if (enable_i) begin
      sym_d = exp_sym(s_q, d_i);
      s_d   = {d_i, s_q[1]};
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      sym_q   <= sym_d;
      valid_q <= enable_i;
    end
  end

  assign valid_o = valid_q;
  assign d_o     = sym_q;

endmodule

// File: rtl/conv_viterbi_codec.sv
// rtl/conv_viterbi_codec.sv - (7,5) encoder plus 4-state hard-decision register-exchange Viterbi decoder
module conv_viterbi_codec
  import conv_codec_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8,
  parameter int PM_INIT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  conv_encoder u_enc (
    .clk      (clk),
    .rst_ni   (rst),
    .enable_i (enc_enable_i),
    .d_i      (enc_d_in),
    .valid_o  (enc_valid_o),
    .d_o      (enc_d_out)
  );

  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [PM_W-1:0]     pm_q     [NUM_STATES];
  logic [PM_W-1:0]     pm_d     [NUM_STATES];
  logic [PM_W-1:0]     cand_min [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d   [NUM_STATES];
  logic [PM_W-1:0]     norm;
  logic [PM_W-1:0]     best_pm;
  state_t              best;
  logic                dec_out_q, dec_out_d;

  // ACS per destination state; predecessors differ only in their s[0] bit.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam state_t NS = state_t'(g);
    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};

    logic [1:0]      bm0, bm1;
    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] c0, c1;
    logic            win;

    assign bm0  = hamming2(dec_d_in, exp_sym(P0, NS[1]));
    assign bm1  = hamming2(dec_d_in, exp_sym(P1, NS[1]));
    assign sum0 = {1'b0, pm_q[P0]} + {{(PM_W-1){1'b0}}, bm0};
    assign sum1 = {1'b0, pm_q[P1]} + {{(PM_W-1){1'b0}}, bm1};
    assign c0   = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
    assign c1   = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
    assign win  = (c1 < c0);

    assign cand_min[g] = win ? c1 : c0;
    assign pm_d[g]     = cand_min[g] - norm;
    assign surv_d[g]   = {(win ? surv_q[P1][TB_DEPTH-2:0] : surv_q[P0][TB_DEPTH-2:0]), NS[1]};
  end

  always_comb begin
    norm = cand_min[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (cand_min[i] < norm) norm = cand_min[i];
    end
  end

  // Output tap selects from the pre-update metrics, lowest index on ties.
  always_comb begin
    best    = '0;
    best_pm = pm_q[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm_q[i] < best_pm) begin
        best    = state_t'(i);
        best_pm = pm_q[i];
      end
    end
    dec_out_d = surv_q[best][TB_DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
        surv_q[i] <= '0;
      end
      dec_out_q <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      dec_out_q <= dec_out_d;
    end
  end

  assign dec_d_out = dec_out_q;

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// tb/tb_conv_viterbi_codec.sv - directed self-checking bench for conv_viterbi_codec
module tb_conv_viterbi_codec;

  localparam int TB   = 16;
  localparam int NSYM = 276;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i, enc_d_in, enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_d_out;

  int total = 0;
  int bad   = 0;
  int burst_errs;
  int dummy_errs;
  logic bits [1:NSYM];

  always #5 clk = ~clk;

  conv_viterbi_codec dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_d_out    (dec_d_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enc_step(input logic en, input logic d, input logic [1:0] exp_sym, input logic exp_vld, input string tag);
    enc_enable_i = en;
    enc_d_in     = d;
    @(posedge clk); #1;
    chk({tag, "_sym"}, enc_d_out, exp_sym);
    chk({tag, "_vld"}, enc_valid_o, exp_vld);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // mode 0: clean with encoder co-driven, 1: single errors, 2: bursts, 3: enable gaps
  task automatic dec_run(input int mode, output int errs);
    logic [1:0] ms, sym;
    logic       en, expb;
    int         k, u, cyc;
    ms = '0; sym = '0; k = 1; u = 0; cyc = 0; errs = 0;
    while (k <= NSYM && cyc < 4 * NSYM) begin
      cyc++;
      en = (mode != 3) || ($urandom_range(0, 2) != 0);
      enc_enable_i = 1'b0;
      if (en) begin
        sym = {bits[k] ^ ms[1] ^ ms[0], bits[k] ^ ms[0]};
        ms  = {bits[k], ms[1]};
        dec_d_in = sym;
        if (mode == 1 && k % 32 == 5) dec_d_in = sym ^ 2'b01;
        if (mode == 2 && (k % 32 == 10 || k % 32 == 11)) dec_d_in = ~sym;
        if (mode == 0) begin
          enc_enable_i = 1'b1;
          enc_d_in     = bits[k];
        end
        k++;
      end else begin
        dec_d_in = 2'($urandom());
      end
      dec_enable = en;
      @(posedge clk); #1;
      if (en) u++;
      expb = (u > TB) ? bits[u - TB] : 1'b0;
      if (mode == 2) begin
        if (dec_d_out !== expb) errs++;
      end else begin
        chk($sformatf("dec_m%0d_u%0d", mode, u), dec_d_out, expb);
      end
      if (mode == 0) chk($sformatf("enc_loop_%0d", u), enc_d_out, sym);
    end
    dec_enable   = 1'b0;
    enc_enable_i = 1'b0;
    chk($sformatf("dec_m%0d_done", mode), k > NSYM, 1);
    if (mode == 2) chk("burst_resync", dec_d_out, bits[NSYM - TB]);
  endtask

  initial begin
    rst = 1'b0; enc_enable_i = 1'b0; enc_d_in = 1'b0; dec_enable = 1'b0; dec_d_in = 2'b00;
    for (int i = 1; i <= NSYM; i++) bits[i] = 1'($urandom_range(0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_enc_vld", enc_valid_o, 0);
    chk("rst_enc_sym", enc_d_out, 0);
    chk("rst_dec_out", dec_d_out, 0);
    rst = 1'b1;

    // Impulse with a one-cycle enable gap after the second symbol.
    enc_step(1'b0, 1'b0, 2'b00, 1'b0, "imp_idle");
    enc_step(1'b1, 1'b1, 2'b11, 1'b1, "imp0");
    enc_step(1'b1, 1'b0, 2'b10, 1'b1, "imp1");
    enc_step(1'b0, 1'b1, 2'b10, 1'b0, "imp_hold");
    enc_step(1'b1, 1'b0, 2'b11, 1'b1, "imp2");
    enc_step(1'b1, 1'b0, 2'b00, 1'b1, "imp3");
    enc_step(1'b1, 1'b0, 2'b00, 1'b1, "imp4");
    enc_step(1'b0, 1'b0, 2'b00, 1'b0, "imp_off");
    async_reset();

    dec_run(0, dummy_errs);

    // Mid-stream async reset: outputs must clear before any clock edge.
    enc_enable_i = 1'b1; enc_d_in = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_vld", enc_valid_o, 1);
    #2 rst = 1'b0;
    #1;
    enc_enable_i = 1'b0;
    chk("async_rst_vld", enc_valid_o, 0);
    chk("async_rst_sym", enc_d_out, 0);
    chk("async_rst_dec", dec_d_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_pm0", dut.pm_q[0], 0);
    chk("rst_pm1", dut.pm_q[1], 32);
    chk("rst_pm2", dut.pm_q[2], 32);
    chk("rst_pm3", dut.pm_q[3], 32);

    dec_run(1, dummy_errs);
    async_reset();
    dec_run(2, burst_errs);
    $display("burst run decoded-bit errors: %0d", burst_errs);
    chk("burst_err_bound", burst_errs <= (NSYM / 32) * TB, 1);
    async_reset();
    dec_run(3, dummy_errs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
